// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU LSU, external requester and data_mem port signals seen by
// dmem_port_arbiter. The slave modport is the arbiter's view. The master modport
// is the surrounding system's view: requesters plus the data_mem read path.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ext_req;
   logic              ext_we;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt;
   logic              ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data_mem port between the CPU load/store path and one
// external requester. CPU has priority; a saturating wait counter forces an
// external win once it has waited STARVE_LIM contended cycles, after which the
// counter clears so the CPU wins the next contended cycle.
// Grants are purely combinational; only the wait counter and the per-owner
// read-return registers hold state.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_LIM = 4
) (
   input logic               clk,
   input logic               rst,
   dmem_port_arbiter_if.slave bus
);

   localparam logic [3:0] LP_LIM = 4'(STARVE_LIM);

   logic [3:0]        r_wait_cnt;
   logic              r_cpu_rvalid;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_ext_rvalid;
   logic [DATA_W-1:0] r_ext_rdata;

   logic              w_starved;
   logic              w_ext_win;
   logic              w_cpu_win;

   // Grant decision; gated by rst so a reset asserted mid-cycle kills any strobe.
   always_comb begin
      w_starved = (r_wait_cnt >= LP_LIM);
      w_ext_win = rst & bus.ext_req & (~bus.cpu_req | w_starved);
      w_cpu_win = rst & bus.cpu_req & ~w_ext_win;
   end

   // Port mux toward data_mem and handshake outputs to both requesters.
   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
      if (w_ext_win) begin
         bus.mem_read  = ~bus.ext_we;
         bus.mem_write = bus.ext_we;
         bus.mem_addr  = bus.ext_addr;
         bus.mem_wdata = bus.ext_wdata;
      end else if (w_cpu_win) begin
         bus.mem_read  = ~bus.cpu_we;
         bus.mem_write = bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end
      bus.ext_gnt    = w_ext_win;
      bus.cpu_stall  = rst & bus.cpu_req & ~w_cpu_win;
      bus.cpu_rvalid = r_cpu_rvalid;
      bus.cpu_rdata  = r_cpu_rdata;
      bus.ext_rvalid = r_ext_rvalid;
      bus.ext_rdata  = r_ext_rdata;
   end

   // Starvation counter: counts denied ext cycles, forfeited on grant or withdrawal.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait_cnt <= 4'd0;
      end else if (bus.ext_req && !w_ext_win) begin
         if (r_wait_cnt != 4'hF) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
         r_wait_cnt <= 4'd0;
      end
   end

   // Read return: capture data_mem output at the granted edge into the owner's register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cpu_rvalid <= 1'b0;
         r_cpu_rdata  <= {DATA_W{1'b0}};
         r_ext_rvalid <= 1'b0;
         r_ext_rdata  <= {DATA_W{1'b0}};
      end else begin
         r_cpu_rvalid <= w_cpu_win & ~bus.cpu_we;
         r_ext_rvalid <= w_ext_win & ~bus.ext_we;
         if (w_cpu_win && !bus.cpu_we) r_cpu_rdata <= bus.mem_rdata;
         if (w_ext_win && !bus.ext_we) r_ext_rdata <= bus.mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous-write,
// combinational-read data_mem model. One table row is one clock cycle.
module tb_dmem_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;

   logic clk;
   logic rst;

   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:255];
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
   assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic cr; logic cw; logic [63:0] ca; logic [63:0] cd;
      logic er; logic ew; logic [63:0] ea; logic [63:0] ed;
      logic x_stall; logic x_gnt; logic x_rd; logic x_wr; logic [63:0] x_addr;
      logic x_crv; logic [63:0] x_crd; logic x_erv; logic [63:0] x_erd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(
      input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
      input logic er, input logic ew, input logic [63:0] ea, input logic [63:0] ed,
      input logic x_stall, input logic x_gnt, input logic x_rd, input logic x_wr,
      input logic [63:0] x_addr, input logic x_crv, input logic [63:0] x_crd,
      input logic x_erv, input logic [63:0] x_erd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
      v.x_stall = x_stall; v.x_gnt = x_gnt; v.x_rd = x_rd; v.x_wr = x_wr;
      v.x_addr = x_addr; v.x_crv = x_crv; v.x_crd = x_crd;
      v.x_erv = x_erv; v.x_erd = x_erd;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
      bus.ext_req = v.er; bus.ext_we = v.ew; bus.ext_addr = v.ea; bus.ext_wdata = v.ed;
   endtask

   task automatic drive_idle();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
   endtask

   localparam logic [63:0] DEAD = 64'hDEAD;
   localparam logic [63:0] H55  = 64'h55;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h30] = 64'h1234;

      // Reset held with both requesters active and a pending write on each side.
      rst = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 64'h40; bus.cpu_wdata = 64'h99;
      bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 64'h48; bus.ext_wdata = 64'h88;
      #22;
      check("rst_cpu_stall",  bus.cpu_stall,  1'b0);
      check("rst_ext_gnt",    bus.ext_gnt,    1'b0);
      check("rst_mem_read",   bus.mem_read,   1'b0);
      check("rst_mem_write",  bus.mem_write,  1'b0);
      check("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      check("rst_cpu_rdata",  bus.cpu_rdata,  64'h0);
      check("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
      check("rst_ext_rdata",  bus.ext_rdata,  64'h0);
      check("rst_mem40",      mem[8'h40],     64'h0);
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b1;

      //  cr cw ca    cd    er ew ea    ed   | stall gnt rd wr addr  crv crd  erv erd
      add(1, 1, 'h10, DEAD, 0, 0, 0,    0,     0, 0, 0, 1, 'h10,  0, 0,    0, 0);
      add(1, 0, 'h10, 0,    0, 0, 0,    0,     0, 0, 1, 0, 'h10,  0, 0,    0, 0);
      add(0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0, 0, 0,     1, DEAD, 0, 0);
      add(0, 0, 0,    0,    1, 1, 'h20, H55,   0, 1, 0, 1, 'h20,  0, DEAD, 0, 0);
      add(0, 0, 0,    0,    1, 0, 'h20, 0,     0, 1, 1, 0, 'h20,  0, DEAD, 0, 0);
      add(0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0, 0, 0,     0, DEAD, 1, H55);
      // continuous contention: CPU wins 4, ext wins 5th, CPU wins 6th
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  0, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     1, 1, 1, 0, 'h20,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  0, DEAD, 1, H55);
      add(0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0, 0, 0,     1, DEAD, 0, H55);
      // ext waits 3 cycles, withdraws, then must wait the full 4 again
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  0, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    0, 0, 0,    0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     0, 0, 1, 0, 'h10,  1, DEAD, 0, H55);
      add(1, 0, 'h10, 0,    1, 0, 'h20, 0,     1, 1, 1, 0, 'h20,  1, DEAD, 0, H55);
      add(0, 0, 0,    0,    0, 0, 0,    0,     0, 0, 0, 0, 0,     0, DEAD, 1, H55);

      // Each row: inputs driven just after a rising edge, outputs sampled mid-cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #5;
         check($sformatf("v%0d_cpu_stall", i),  bus.cpu_stall,  vecs[i].x_stall);
         check($sformatf("v%0d_ext_gnt", i),    bus.ext_gnt,    vecs[i].x_gnt);
         check($sformatf("v%0d_mem_read", i),   bus.mem_read,   vecs[i].x_rd);
         check($sformatf("v%0d_mem_write", i),  bus.mem_write,  vecs[i].x_wr);
         check($sformatf("v%0d_mem_addr", i),   bus.mem_addr,   vecs[i].x_addr);
         check($sformatf("v%0d_cpu_rvalid", i), bus.cpu_rvalid, vecs[i].x_crv);
         check($sformatf("v%0d_cpu_rdata", i),  bus.cpu_rdata,  vecs[i].x_crd);
         check($sformatf("v%0d_ext_rvalid", i), bus.ext_rvalid, vecs[i].x_erv);
         check($sformatf("v%0d_ext_rdata", i),  bus.ext_rdata,  vecs[i].x_erd);
         @(posedge clk); #1;
      end
      check("mem10_after_store", mem[8'h10], DEAD);
      check("mem20_after_write", mem[8'h20], H55);

      // Ext read granted, then reset lands mid-cycle during the following ext write.
      drive_idle();
      bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 64'h10;
      #3;
      check("seq_rd_gnt", bus.ext_gnt, 1'b1);
      @(posedge clk); #1;
      bus.ext_we = 1'b1; bus.ext_addr = 64'h30; bus.ext_wdata = 64'h77;
      #2;
      check("seq_rvalid_before_rst", bus.ext_rvalid, 1'b1);
      check("seq_rdata_before_rst",  bus.ext_rdata,  DEAD);
      check("seq_wr_before_rst",     bus.mem_write,  1'b1);
      check("seq_gnt_before_rst",    bus.ext_gnt,    1'b1);
      rst = 1'b0;
      #1;
      check("seq_wr_in_rst",     bus.mem_write,  1'b0);
      check("seq_gnt_in_rst",    bus.ext_gnt,    1'b0);
      check("seq_rvalid_in_rst", bus.ext_rvalid, 1'b0);
      check("seq_rdata_in_rst",  bus.ext_rdata,  64'h0);
      @(posedge clk); #1;
      check("seq_mem30_kept", mem[8'h30], 64'h1234);
      drive_idle();
      rst = 1'b1;
      #4;
      check("seq_no_resp_after_rst", bus.ext_rvalid, 1'b0);
      @(posedge clk); #1;
      check("seq_no_resp_later", bus.ext_rvalid, 1'b0);
      check("seq_cpu_rvalid_idle", bus.cpu_rvalid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
